// File: rtl/msrv32_irq_pkg.sv
// Shared types, cause codes and priority helpers for the msrv32 machine-mode interrupt controller.
package msrv32_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_IN_TRAP = 2'd2
    } irq_state_t;

    localparam int CAUSE_W = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_MSI = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;

    // ep bit order is {MEI, MSI, MTI}; MEI wins over MSI, which wins over MTI.
    function automatic logic [CAUSE_W-1:0] prio_cause(input logic [2:0] ep);
        logic [CAUSE_W-1:0] cause;
        if (ep[2]) begin
            cause = CAUSE_MEI;
        end else if (ep[1]) begin
            cause = CAUSE_MSI;
        end else if (ep[0]) begin
            cause = CAUSE_MTI;
        end else begin
            cause = 4'd0;
        end
        return cause;
    endfunction

    function automatic logic cause_active(input logic [CAUSE_W-1:0] cause,
                                          input logic [2:0]         ep);
        logic active;
        case (cause)
            CAUSE_MEI: active = ep[2];
            CAUSE_MSI: active = ep[1];
            CAUSE_MTI: active = ep[0];
            default:   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/msrv32_irq_sync.sv
// N-stage single-bit flop synchronizer with synchronous active-high reset.
module msrv32_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw level through the chain; the last flop is the synchronized output.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/msrv32_irq_ctrl.sv
// Machine-mode interrupt controller: registers/masks irq lines, raises a prioritised request and tracks trap residency.
// Optional build macro MSRV32_IRQ_SYNC_EN inserts a SYNC_STAGES-deep synchronizer per interrupt line.
module msrv32_irq_ctrl
    import msrv32_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               ms_riscv32_mp_clk_in,
    input  logic               ms_riscv32_mp_rst_in,
    input  logic               ms_riscv32_mp_eirq_in,
    input  logic               ms_riscv32_mp_tirq_in,
    input  logic               ms_riscv32_mp_sirq_in,
    input  logic               mstatus_mie_in,
    input  logic               mie_meie_in,
    input  logic               mie_mtie_in,
    input  logic               mie_msie_in,
    input  logic               irq_ack_in,
    input  logic               mret_in,
    output logic               irq_req_out,
    output logic [CAUSE_W-1:0] irq_cause_out,
    output logic               mip_meip_out,
    output logic               mip_mtip_out,
    output logic               mip_msip_out,
    output logic               in_trap_out
);

    logic               clk;
    logic               rst;
    logic [2:0]         mip_s;
    logic [2:0]         ep_s;
    irq_state_t         state_r;
    logic               req_r;
    logic               trap_r;
    logic [CAUSE_W-1:0] cause_r;

    assign clk = ms_riscv32_mp_clk_in;
    assign rst = ms_riscv32_mp_rst_in;

`ifdef MSRV32_IRQ_SYNC_EN
    // The final synchronizer flop doubles as the mip register, giving SYNC_STAGES cycles of latency.
    msrv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_e (
        .clk (clk), .rst (rst), .d (ms_riscv32_mp_eirq_in), .q (mip_s[2])
    );
    msrv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_s (
        .clk (clk), .rst (rst), .d (ms_riscv32_mp_sirq_in), .q (mip_s[1])
    );
    msrv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_t (
        .clk (clk), .rst (rst), .d (ms_riscv32_mp_tirq_in), .q (mip_s[0])
    );
`else
    if (SYNC_STAGES > 0) begin : g_mip_direct
        logic [2:0] mip_r;

        // Single register stage per line; sources are already synchronous to clk.
        always_ff @(posedge clk) begin
            if (rst) begin
                mip_r <= 3'b000;
            end else begin
                mip_r <= {ms_riscv32_mp_eirq_in, ms_riscv32_mp_sirq_in, ms_riscv32_mp_tirq_in};
            end
        end

        assign mip_s = mip_r;
    end
`endif

    // Enabled-pending vector in {MEI, MSI, MTI} order.
    always_comb begin
        ep_s = mip_s & {mie_meie_in, mie_msie_in, mie_mtie_in};
    end

    // Request/acknowledge handshake FSM with registered request, trap and cause outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            trap_r  <= 1'b0;
            cause_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mstatus_mie_in && (ep_s != 3'b000)) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        cause_r <= prio_cause(ep_s);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Acknowledge takes precedence over a same-cycle withdrawal.
                    if (irq_ack_in) begin
                        state_r <= ST_IN_TRAP;
                        req_r   <= 1'b0;
                        trap_r  <= 1'b1;
                    end else if (!mstatus_mie_in || !cause_active(cause_r, ep_s)) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_IN_TRAP: begin
                    if (mret_in) begin
                        state_r <= ST_IDLE;
                        trap_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IN_TRAP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    trap_r  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_out   = req_r;
    assign in_trap_out   = trap_r;
    assign irq_cause_out = cause_r;
    assign mip_meip_out  = mip_s[2];
    assign mip_msip_out  = mip_s[1];
    assign mip_mtip_out  = mip_s[0];

endmodule

// File: tb/tb_msrv32_irq_ctrl.sv
// Self-checking bench for msrv32_irq_ctrl: per-cycle model comparison plus directed literal checks.
module tb_msrv32_irq_ctrl;

    localparam int SS = 2;
`ifdef MSRV32_IRQ_SYNC_EN
    localparam int LAT = SS;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eirq = 1'b0, tirq = 1'b0, sirq = 1'b0;
    logic       mie = 1'b0, meie = 1'b0, mtie = 1'b0, msie = 1'b0;
    logic       ack = 1'b0, mret = 1'b0;
    logic       req, meip, mtip, msip, trap;
    logic [3:0] cause;

    int total_cnt = 0;
    int pass_cnt  = 0;

    msrv32_irq_ctrl #(.SYNC_STAGES(SS)) dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_in  (rst),
        .ms_riscv32_mp_eirq_in (eirq),
        .ms_riscv32_mp_tirq_in (tirq),
        .ms_riscv32_mp_sirq_in (sirq),
        .mstatus_mie_in        (mie),
        .mie_meie_in           (meie),
        .mie_mtie_in           (mtie),
        .mie_msie_in           (msie),
        .irq_ack_in            (ack),
        .mret_in               (mret),
        .irq_req_out           (req),
        .irq_cause_out         (cause),
        .mip_meip_out          (meip),
        .mip_mtip_out          (mtip),
        .mip_msip_out          (msip),
        .in_trap_out           (trap)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Source table in priority order: MEI, MSI, MTI.
    int  m_code [3] = '{11, 3, 7};
    bit  hist [3][LAT];        // per-source delay line, index 0 = newest sample
    bit  m_req = 0, m_trap = 0, m_valid = 0;
    int  m_cause = 0;

    function automatic bit m_mip(input int src);
        return hist[src][LAT-1];
    endfunction

    function automatic bit m_ep(input int src);
        bit en;
        case (src)
            0:       en = meie;
            1:       en = msie;
            default: en = mtie;
        endcase
        return m_mip(src) & en;
    endfunction

    always @(posedge clk) begin
        bit lines [3];
        bit any_ep;
        lines = '{eirq, sirq, tirq};
        if (rst) begin
            m_req = 0; m_trap = 0; m_cause = 0;
            foreach (hist[s, k]) hist[s][k] = 0;
            m_valid = 1;
        end else begin
            if (m_trap) begin
                if (mret) m_trap = 0;
            end else if (m_req) begin
                if (ack) begin
                    m_req = 0; m_trap = 1;
                end else begin
                    bit still;
                    still = 0;
                    for (int s = 0; s < 3; s++)
                        if (m_code[s] == m_cause) still = m_ep(s);
                    if (!mie || !still) m_req = 0;
                end
            end else begin
                any_ep = 0;
                for (int s = 0; s < 3; s++) begin
                    if (!any_ep && m_ep(s)) begin
                        any_ep = 1;
                        m_cause = m_code[s];
                    end
                end
                if (mie && any_ep) m_req = 1;
            end
            for (int s = 0; s < 3; s++) begin
                for (int k = LAT - 1; k > 0; k--) hist[s][k] = hist[s][k-1];
                hist[s][0] = lines[s];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("req",   int'(req),   int'(m_req));
            chk("trap",  int'(trap),  int'(m_trap));
            chk("cause", int'(cause), m_cause);
            chk("meip",  int'(meip),  int'(m_mip(0)));
            chk("msip",  int'(msip),  int'(m_mip(1)));
            chk("mtip",  int'(mtip),  int'(m_mip(2)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic outs(input string tag, input int e_req, input int e_trap, input int e_cause);
        chk({tag, "_req"},   int'(req),   e_req);
        chk({tag, "_trap"},  int'(trap),  e_trap);
        chk({tag, "_cause"}, int'(cause), e_cause);
    endtask

    initial begin
        step(2);
        outs("reset", 0, 0, 0);
        chk("reset_mip", int'({meip, msip, mtip}), 0);
        rst = 1'b0;

        // Timer only: mip after LAT, request one cycle later with cause 7.
        mie = 1'b1; mtie = 1'b1; tirq = 1'b1;
        step(LAT);
        chk("t_mtip", int'(mtip), 1);
        chk("t_req_early", int'(req), 0);
        step(1);
        outs("t_req", 1, 0, 7);
        ack = 1'b1; step(1); ack = 1'b0;
        outs("t_ack", 0, 1, 7);
        mret = 1'b1; mtie = 1'b0; tirq = 1'b0; step(1); mret = 1'b0;
        outs("t_mret", 0, 0, 7);
        step(LAT + 2);

        // All three sources: MEI first, then MSI once eirq drops.
        eirq = 1'b1; sirq = 1'b1; tirq = 1'b1; meie = 1'b1; msie = 1'b1; mtie = 1'b1;
        step(LAT + 1);
        outs("all_req", 1, 0, 11);
        ack = 1'b1; step(1); ack = 1'b0; eirq = 1'b0;
        step(LAT + 1);
        outs("all_intrap", 0, 1, 11);
        mret = 1'b1; step(1); mret = 1'b0;
        step(1);
        outs("msi_req", 1, 0, 3);

        // Withdrawal when msie drops, then ack winning over the same withdrawal.
        msie = 1'b0; mtie = 1'b0; step(1);
        outs("withdraw", 0, 0, 3);
        msie = 1'b1; step(1);
        outs("msi_again", 1, 0, 3);
        msie = 1'b0; ack = 1'b1; step(1); ack = 1'b0;
        outs("ack_wins", 0, 1, 3);
        mret = 1'b1; sirq = 1'b0; tirq = 1'b0; meie = 1'b0; step(1); mret = 1'b0;
        step(LAT + 2);

        // Frozen cause: MTI request, MEI arrives later, mret in REQ ignored.
        mtie = 1'b1; tirq = 1'b1; step(LAT + 1);
        outs("mti_req", 1, 0, 7);
        eirq = 1'b1; meie = 1'b1; mret = 1'b1; step(LAT + 2); mret = 1'b0;
        outs("frozen", 1, 0, 7);
        ack = 1'b1; step(1); ack = 1'b0;
        outs("frozen_ack", 0, 1, 7);

        // In trap with every source pending: no request until after mret.
        sirq = 1'b1; msie = 1'b1; ack = 1'b1; step(3); ack = 1'b0;
        outs("trap_block", 0, 1, 7);
        mret = 1'b1; step(1); mret = 1'b0;
        outs("mret_edge", 0, 0, 7);
        step(1);
        outs("after_mret", 1, 0, 11);

        // Reset in REQ and in IN_TRAP clears everything, mip included.
        rst = 1'b1; step(1);
        outs("rst_req", 0, 0, 0);
        chk("rst_req_mip", int'({meip, msip, mtip}), 0);
        rst = 1'b0; step(LAT + 1);
        outs("rst_rereq", 1, 0, 11);
        ack = 1'b1; step(1); ack = 1'b0;
        rst = 1'b1; step(1);
        outs("rst_trap", 0, 0, 0);
        chk("rst_trap_mip", int'({meip, msip, mtip}), 0);
        rst = 1'b0;
        eirq = 1'b0; sirq = 1'b0; tirq = 1'b0; meie = 1'b0; msie = 1'b0; mtie = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/msrv32_irq_ctrl.md
# msrv32_irq_ctrl

Machine-mode interrupt controller sitting directly downstream of the msrv32 interrupt interface. Registers the raw external, timer and software interrupt lines and masks them with the CSR enables. Picks the highest-priority enabled pending source and presents it to the trap unit as a request/acknowledge handshake with a frozen cause code. Tracks trap residency until `mret`.

## Interface
- SYNC_STAGES, 2, synchronizer depth per interrupt line (only used when MSRV32_IRQ_SYNC_EN is defined; legal 2..4)
- ms_riscv32_mp_clk_in  input  1  single core clock; all logic on its rising edge
- ms_riscv32_mp_rst_in  input  1  reset, synchronous and active-high
- ms_riscv32_mp_eirq_in  input  1  external interrupt level
- ms_riscv32_mp_tirq_in  input  1  timer interrupt level
- ms_riscv32_mp_sirq_in  input  1  software interrupt level
- mstatus_mie_in  input  1  global machine interrupt enable
- mie_meie_in / mie_mtie_in / mie_msie_in  input  1 each  per-source enables
- irq_ack_in  input  1  trap unit accepts the current request
- mret_in  input  1  trap return retired
- irq_req_out  output  1  interrupt request to trap unit
- irq_cause_out  output  4  mcause code of the request (11 MEI, 3 MSI, 7 MTI)
- mip_meip_out / mip_mtip_out / mip_msip_out  output  1 each  registered pending bits for the mip CSR
- in_trap_out  output  1  high from acknowledge until mret

## Operation
- Pending bits (mip) are level-sensitive copies of the registered inputs; there is no edge latching.
- Enabled-pending vector: ep = {meip&meie, msip&msie, mtip&mtie}.
- Priority: MEI > MSI > MTI.
- FSM states are IDLE, REQ and IN_TRAP; state is registered.
- IDLE → REQ when mstatus_mie_in=1 and ep≠0. The cause of the winning source is captured into the cause register on this transition.
- REQ:
  - irq_ack_in=1 → IN_TRAP. Acknowledge wins over any simultaneous withdrawal condition.
  - Else, if the captured source is no longer enabled-pending, or mstatus_mie_in=0 → IDLE (request withdrawn).
  - Else stay in REQ. The cause stays frozen even if a higher-priority source arrives.
- IN_TRAP: mret_in=1 → IDLE. New requests are never raised in IN_TRAP, and irq_ack_in is ignored there.
- mret_in in IDLE or REQ is ignored.
- irq_req_out = (state==REQ).
- in_trap_out = (state==IN_TRAP).
- irq_cause_out holds its last captured value outside REQ.
- Reset values: state IDLE, irq_req_out 0, irq_cause_out 0, all mip outputs 0, in_trap_out 0, synchronizer flops 0.
- Reset asserted mid-handshake: the FSM returns to IDLE the next edge, with no request and no trap residency retained.

## Timing
- Input to mip latency:
  - SYNC_STAGES cycles with MSRV32_IRQ_SYNC_EN.
  - 1 cycle without it.
- mip to irq_req_out: 1 cycle, when IDLE and enabled.
- Acknowledge: irq_req_out drops the cycle after irq_ack_in is sampled high; in_trap_out rises the same cycle.
- mret sampled at edge t: state is IDLE after t. The earliest new irq_req_out is after edge t+1, one cycle later.
- Withdrawal: irq_req_out drops the cycle after the captured source's ep bit or mstatus_mie_in is sampled low.
- irq_cause_out is stable for the whole time irq_req_out is high.

## Configuration
- MSRV32_IRQ_SYNC_EN:
  - Defined: each of the three interrupt lines passes through a SYNC_STAGES-deep flop synchronizer before the mip register. Use this for asynchronous sources.
  - Undefined: a single register stage per line. Sources must be synchronous to ms_riscv32_mp_clk_in, and SYNC_STAGES is ignored.

## Structure
- msrv32_irq_pkg:
  - state enum (IDLE, REQ, IN_TRAP)
  - CAUSE_W=4
  - cause constants CAUSE_MEI=4'd11, CAUSE_MSI=4'd3, CAUSE_MTI=4'd7
  - priority-encode function returning the cause from ep
- Sub-module msrv32_irq_sync: a parameterised N-stage single-bit synchronizer with synchronous active-high reset. It is instantiated three times under MSRV32_IRQ_SYNC_EN.

## Test plan
- Reset then tirq_in=1, mtie=1, mstatus_mie=1:
  - mip_mtip_out=1 after SYNC_STAGES cycles.
  - irq_req_out=1 one cycle later, irq_cause_out=7.
- eirq, sirq and tirq all high together, all enabled → cause=11. After ack and mret, with eirq low, the next request has cause=3.
- Withdrawal:
  - Request with cause 3 pending and no ack, then mie_msie drops → irq_req_out=0 next cycle, state IDLE.
  - Same with the ack asserted in that same cycle → in_trap_out=1 instead.
- During REQ with cause 7, eirq rises → cause stays 7 until ack. After mret, the following request has cause 11 one cycle later.
- IN_TRAP with all sources high → irq_req_out stays 0. mret at t → irq_req_out=1 after t+1.
- Reset asserted while in REQ and while in IN_TRAP → all outputs 0 on the next cycle, including mip outputs and cause.
